// File: rtl/svm_vector_source.sv
// Test-vector transmitter for the SVM classifier: buffers one vector from the host,
// replays it to the classifier, then returns the label tagged with a running index.
module svm_vector_source #(
   parameter int WORDS = 32,
   parameter int IDX_W = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [31:0]      in_data,
   input  logic             in_valid,
   output logic             in_ready,
   output logic [31:0]      test,
   output logic             test_valid,
   input  logic             test_ready,
   input  logic             label,
   input  logic             label_valid,
   output logic             label_ready,
   output logic             res_label,
   output logic [IDX_W-1:0] res_index,
   output logic             res_valid,
   input  logic             res_ready,
   output logic             busy
);
   localparam int AW = $clog2(WORDS);
   localparam logic [AW-1:0] LAST = AW'(WORDS - 1);

   typedef enum logic [1:0] {FILL, SEND, WAIT, REPORT} state_t;

   state_t        state, state_nx;
   logic [31:0]   mem [WORDS];
   logic [AW-1:0] wp, rp;
   logic          in_fire, test_fire, label_fire, res_fire;

   assign in_fire    = in_valid && in_ready;
   assign test_fire  = test_valid && test_ready;
   assign label_fire = label_valid && label_ready;
   assign res_fire   = res_valid && res_ready;

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) state <= FILL;
      else      state <= state_nx;
   end

   // Handshake outputs depend on state only; inputs steer just the next state.
   always_comb begin
      state_nx    = state;
      in_ready    = 1'b0;
      test_valid  = 1'b0;
      label_ready = 1'b0;
      res_valid   = 1'b0;
      case (state)
         FILL: begin
            in_ready = 1'b1;
            if (in_valid && wp == LAST) state_nx = SEND;
         end
         SEND: begin
            test_valid = 1'b1;
            if (test_ready && rp == LAST) state_nx = WAIT;
         end
         WAIT: begin
            label_ready = 1'b1;
            if (label_valid) state_nx = REPORT;
         end
         REPORT: begin
            res_valid = 1'b1;
            if (res_ready) state_nx = FILL;
         end
         default: state_nx = FILL;
      endcase
   end

   // Pointers wrap explicitly so non-power-of-two depths work.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         wp        <= '0;
         rp        <= '0;
         res_label <= 1'b0;
         res_index <= '0;
      end else begin
         if (in_fire) begin
            if (wp == LAST) begin
               wp <= '0;
               rp <= '0;
            end else begin
               wp <= wp + AW'(1);
            end
         end
         if (test_fire) rp <= (rp == LAST) ? '0 : rp + AW'(1);
         if (label_fire) res_label <= label;
         if (res_fire) res_index <= res_index + IDX_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (in_fire) mem[wp] <= in_data;
   end

   assign test = mem[rp];
   assign busy = !(state == FILL && wp == '0);

endmodule

// File: tb/tb_svm_vector_source.sv
// Scoreboard bench for svm_vector_source: drivers push expected words/results,
// a negedge monitor pops and compares on every handshake.
module tb_svm_vector_source;
   localparam int WORDS = 32;
   localparam int IDX_W = 2;

   logic             clk = 1'b0;
   logic             rst = 1'b0;
   logic [31:0]      in_data = '0;
   logic             in_valid = 1'b0;
   logic             in_ready;
   logic [31:0]      test;
   logic             test_valid;
   logic             test_ready = 1'b1;
   logic             label = 1'b0;
   logic             label_valid = 1'b0;
   logic             label_ready;
   logic             res_label;
   logic [IDX_W-1:0] res_index;
   logic             res_valid;
   logic             res_ready = 1'b1;
   logic             busy;

   svm_vector_source #(.WORDS(WORDS), .IDX_W(IDX_W)) dut (
      .clk(clk), .rst(rst),
      .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
      .test(test), .test_valid(test_valid), .test_ready(test_ready),
      .label(label), .label_valid(label_valid), .label_ready(label_ready),
      .res_label(res_label), .res_index(res_index), .res_valid(res_valid),
      .res_ready(res_ready), .busy(busy)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic             lbl;
      logic [IDX_W-1:0] idx;
   } res_t;

   int          checks = 0;
   int          errors = 0;
   logic [31:0] exp_test[$];
   res_t        exp_res[$];
   bit          bp = 1'b0;
   int          n_test = 0;
   int          n_in = 0;
   int          n_lbl = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   task automatic fail(input string name);
      checks++;
      errors++;
      $display("FAIL %s: timeout or unexpected event", name);
   endtask

   always @(posedge clk) begin
      #1;
      test_ready = bp ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor: handshakes seen at negedge complete on the following posedge.
   logic             want_tv = 0, want_lr = 0, want_rv = 0, want_ir = 0;
   logic             pv_tv = 0, pv_tr = 0, pv_rv = 0, pv_rr = 0, pv_rl = 0;
   logic [31:0]      pv_test = '0;
   logic [IDX_W-1:0] pv_ri = '0;
   res_t             r;

   always @(negedge clk) begin
      if (!rst) begin
         exp_test.delete();
         exp_res.delete();
         n_test = 0; n_in = 0; n_lbl = 0;
         want_tv = 0; want_lr = 0; want_rv = 0; want_ir = 0;
         pv_tv = 0; pv_rv = 0;
      end else begin
         if (want_tv) chk("fill_to_send", test_valid, 1);
         if (want_lr) chk("send_to_wait", label_ready, 1);
         if (want_rv) chk("wait_to_report", res_valid, 1);
         if (want_ir) chk("report_to_fill", in_ready, 1);
         want_tv = 0; want_lr = 0; want_rv = 0; want_ir = 0;
         if (pv_tv && !pv_tr) begin
            chk("test_hold", test, pv_test);
            chk("test_valid_hold", test_valid, 1);
         end
         if (pv_rv && !pv_rr) begin
            chk("res_hold", {res_valid, res_label, res_index}, {1'b1, pv_rl, pv_ri});
            chk("in_ready_in_report", in_ready, 0);
         end
         if (label_ready) chk("label_ready_gate", n_test, WORDS);
         if (in_valid && in_ready) begin
            n_in++;
            if (n_in == WORDS) begin
               n_in = 0;
               want_tv = 1;
            end
         end
         if (test_valid && test_ready) begin
            if (exp_test.size() == 0) fail("test_unexpected");
            else chk("test_word", test, exp_test.pop_front());
            n_test++;
            if (n_test == WORDS) want_lr = 1;
         end
         if (label_valid && label_ready) begin
            n_lbl++;
            n_test = 0;
            want_rv = 1;
         end
         if (res_valid && res_ready) begin
            chk("label_count", n_lbl, 1);
            n_lbl = 0;
            if (exp_res.size() == 0) fail("res_unexpected");
            else begin
               r = exp_res.pop_front();
               chk("res_label", res_label, r.lbl);
               chk("res_index", res_index, r.idx);
            end
            want_ir = 1;
         end
         pv_tv = test_valid; pv_tr = test_ready; pv_test = test;
         pv_rv = res_valid; pv_rr = res_ready; pv_rl = res_label; pv_ri = res_index;
      end
   end

   task automatic fill(input logic [31:0] base);
      int t;
      for (int i = 0; i < WORDS; i++) begin
         t = 0;
         in_valid = 1'b1;
         in_data  = base + i;
         @(negedge clk);
         while (!in_ready && t < 500) begin
            t++;
            @(negedge clk);
         end
         if (!in_ready) begin
            fail("fill_wait");
            break;
         end
         if (i < 2) chk("busy", busy, (i != 0));
         exp_test.push_back(in_data);
         @(posedge clk);
         #1;
      end
      in_valid = 1'b0;
   endtask

   task automatic drive_label(input logic lbl, input bit early);
      int t;
      t = 0;
      if (!early) begin
         while (n_test < WORDS && t < 1000) begin
            @(posedge clk);
            t++;
         end
         #1;
         label_valid = 1'b1;
         label       = lbl;
      end
      t = 0;
      @(negedge clk);
      while (!label_ready && t < 1000) begin
         t++;
         @(negedge clk);
      end
      if (!label_ready) fail("label_wait");
      @(posedge clk);
      #1;
      label_valid = 1'b0;
   endtask

   task automatic take_result(input bit stall);
      int t;
      t = 0;
      res_ready = !stall;
      @(negedge clk);
      while (!res_valid && t < 2000) begin
         t++;
         @(negedge clk);
      end
      if (!res_valid) fail("result_wait");
      if (stall) begin
         repeat (10) @(negedge clk);
         @(posedge clk);
         #1;
         res_ready = 1'b1;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_vector(input logic [31:0] base, input logic lbl, input bit bpm,
                             input bit early, input bit stall, input logic [IDX_W-1:0] idx);
      exp_res.push_back(res_t'{lbl, idx});
      bp = bpm;
      if (early) begin
         label_valid = 1'b1;
         label       = lbl;
      end
      fork
         fill(base);
         drive_label(lbl, early);
         take_result(stall);
      join
      bp = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation did not finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int t;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_test_valid", test_valid, 0);
      chk("rst_label_ready", label_ready, 0);
      chk("rst_res_valid", res_valid, 0);
      chk("rst_busy", busy, 0);
      chk("rst_res", {res_label, res_index}, 0);
      rst = 1'b1;
      @(posedge clk);
      #1;

      run_vector(32'h0000_0000, 1'b1, 0, 0, 0, 2'd0);  // basic
      run_vector(32'h1000_0000, 1'b0, 1, 0, 0, 2'd1);  // random back-pressure
      run_vector(32'hA5A5_0000, 1'b0, 0, 1, 0, 2'd2);  // early label
      run_vector(32'h5A00_0100, 1'b1, 0, 0, 1, 2'd3);  // result stall
      run_vector(32'hFFFF_FFE0, 1'b1, 1, 0, 0, 2'd0);  // index wrap

      // Abort a vector after 17 words have gone out.
      fill(32'h0BAD_0000);
      t = 0;
      while (n_test < 17 && t < 1000) begin
         @(posedge clk);
         t++;
      end
      if (n_test != 17) fail("abort_wait");
      #1;
      rst = 1'b0;
      #1;
      chk("abort_test_valid", test_valid, 0);
      chk("abort_in_ready", in_ready, 1);
      chk("abort_busy", busy, 0);
      chk("abort_res_index", res_index, 0);
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b1;
      @(posedge clk);
      #1;
      run_vector(32'h7700_0000, 1'b1, 0, 0, 0, 2'd0);

      repeat (3) @(posedge clk);
      chk("exp_test_drained", exp_test.size(), 0);
      chk("exp_res_drained", exp_res.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
